dmem_bridge: RTL and testbench
==============================

# dmem_bridge

Data-memory bridge for the 1-stage RV32I core. It consumes the datapath's combinational data-memory request (address, write data, byte mask, access strobe) and turns it into a registered valid/ready request with a separate response channel. It returns the load word to the datapath and drives `Dwait` so the PC and register file stall until the access completes. Bus errors and timeouts are reported through a sticky flag.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles spent in REQ+WAIT before the access is aborted (1..65535).
- `ERR_RDATA`, default 32'hDEAD_BEEF: load data returned on error or timeout.

- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low.
- `memaccess` in 1: datapath requests a load or store this cycle.
- `memwrite` in 1: 1 = store, 0 = load; valid when `memaccess` is high.
- `addr` in 32: byte address (datapath ALU output).
- `wdata` in 32: store data, already lane-aligned.
- `wmask` in 4: store byte enables.
- `rdata` out 32: full load word to the datapath.
- `Dwait` out 1: stall request to the datapath.
- `bus_req_valid` out 1: request valid.
- `bus_req_ready` in 1: request accepted.
- `bus_req_we` out 1: write request.
- `bus_req_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `bus_req_wdata` out 32: store data.
- `bus_req_strb` out 4: `wmask` for stores, 4'b0000 for loads.
- `bus_rsp_valid` in 1: response valid. Accepted unconditionally; there is no rsp ready.
- `bus_rsp_rdata` in 32: response data.
- `bus_rsp_err` in 1: response error, qualified by `bus_rsp_valid`.
- `err` out 1: sticky error flag.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - `Dwait = memaccess` (combinational).
  - If `memaccess`: latch `memwrite`, word address, `wdata`, and strb into request registers, then go to REQ.
- **REQ**
  - `bus_req_valid = 1`; request fields are driven from the registers and stay stable until accepted.
  - `Dwait = 1`.
  - On `valid & ready`: go to WAIT.
- **WAIT**
  - `Dwait = 1`.
  - On `bus_rsp_valid`:
    - Latch `bus_rsp_rdata` into the rdata register, or `ERR_RDATA` if `bus_rsp_err`.
    - Set `err` if `bus_rsp_err`.
    - Go to DONE.
  - A response that arrives in the same cycle as the REQ handshake is not legal and is ignored.
- **DONE**
  - `Dwait = 0`, so the datapath commits this cycle.
  - `rdata` = latched register.
  - Go to IDLE unconditionally. `memaccess` is not sampled in DONE, which prevents re-issuing the committed access.
- **Stores**: the response is still required (write ack). Its `rdata` is latched but unused.
- **Timeout**
  - A 16-bit counter clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When it reaches `TIMEOUT_CYCLES`, abort: drop `bus_req_valid`, load `ERR_RDATA`, set `err`, go to DONE.
  - A `bus_rsp_valid` arriving in the same cycle as the timeout takes priority over the timeout.
- **Stray responses** (`bus_rsp_valid` in IDLE, REQ, or DONE) are ignored. Such a response does not set `err`.
- `rdata` holds its last latched value outside DONE.

## Timing
- Reset values: state=IDLE; `bus_req_valid`=0; `bus_req_we`=0; `bus_req_addr`/`wdata`/`strb`=0; `rdata`=0; `err`=0; counter=0.
- `Dwait` is 0 in reset only while `memaccess` is 0.
- Minimum access, request issued at cycle N with ready=1 and a 1-cycle response:
  - N: IDLE, `Dwait`=1.
  - N+1: REQ, handshake.
  - N+2: WAIT, `rsp_valid`.
  - N+3: DONE, `Dwait`=0, commit.
  - Total: 4 cycles per memory instruction.
- Non-memory instructions see no added latency.
- Reset asserted mid-access: all state clears asynchronously and `bus_req_valid` falls without waiting for a clock. Any in-flight response after reset release is a stray response and is ignored.
- `err` clears only on reset.

## Structure
- Package `dmem_bridge_pkg` holds:
  - the `dmem_state_e` enum (IDLE, REQ, WAIT, DONE);
  - a default `ERR_RDATA` constant;
  - a request struct `dmem_req_t` {we, addr, wdata, strb}.
- Single flat module; no sub-module needed.
- The FSM is one `always_ff` plus one `always_comb` for `Dwait` and next-state.

## Test plan
- Load, ready=1, response 1 cycle after accept with rdata=32'h1234_5678, addr=32'h0000_1006 -> `bus_req_addr`=32'h0000_1004, strb=0, `Dwait` high 3 cycles, `rdata`=32'h1234_5678 in DONE, `err`=0.
- Store addr=32'h20, wdata=32'hAABB_CCDD, wmask=4'b1100, ready withheld 5 cycles -> valid and fields stable for 5 cycles, we=1, strb=4'b1100, `Dwait` high until DONE.
- Back-to-back load then store (memaccess held high through DONE) -> exactly two bus requests, second issued from the IDLE following DONE.
- `TIMEOUT_CYCLES`=8, no ready -> valid drops after 8 cycles, `rdata`=32'hDEAD_BEEF, `err`=1 and remains 1 through later successful accesses.
- `bus_rsp_err`=1 on response -> `rdata`=`ERR_RDATA`, `err`=1; a stray `bus_rsp_valid` pulse in IDLE -> no state change, `err` unaffected.
- Reset pulsed in WAIT -> `bus_req_valid`, `rdata`, and `err` at 0 immediately; state IDLE; a late response after release is ignored.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory bridge.
package dmem_bridge_pkg;

    // Bridge FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } dmem_state_e;

    // Load data handed back to the datapath when an access fails or times out.
    localparam logic [31:0] DMEM_ERR_RDATA = 32'hDEAD_BEEF;

    // Request fields held stable on the bus until the handshake completes.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } dmem_req_t;

endpackage

// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns the single-cycle core's combinational memory
// strobe into a registered valid/ready request plus a response channel,
// stalling the datapath through Dwait until the access commits.
//
// state | meaning
// IDLE  | no access in flight; Dwait follows memaccess
// REQ   | request presented on the bus, waiting for ready
// WAIT  | request accepted, waiting for the response
// DONE  | result latched; Dwait low so the datapath commits
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = DMEM_ERR_RDATA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memaccess,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    output logic [31:0] rdata,
    output logic        Dwait,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_we,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_wdata,
    output logic [3:0]  bus_req_strb,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata,
    input  logic        bus_rsp_err,
    output logic        err
);

    // Counter value seen in the last permitted REQ/WAIT cycle; the abort
    // happens at the end of that cycle, so exactly TIMEOUT_CYCLES cycles
    // are spent in REQ+WAIT before DONE.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    dmem_state_e r_state;
    dmem_state_e w_state_nxt;
    dmem_req_t   r_req;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [15:0] r_cnt;
    logic        w_dwait;
    logic        w_timeout;

    assign w_timeout = (r_cnt == TO_LAST);

    // Next-state and stall decode; a response on the timeout cycle wins.
    always_comb begin
        w_state_nxt = r_state;
        w_dwait     = 1'b0;
        case (r_state)
            IDLE: begin
                w_dwait = memaccess;
                if (memaccess) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                w_dwait = 1'b1;
                if (w_timeout) begin
                    w_state_nxt = DONE;
                end else if (bus_req_ready) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                w_dwait = 1'b1;
                if (bus_rsp_valid || w_timeout) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, request capture, response/timeout capture and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_req   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (memaccess) begin
                        r_req.we    <= memwrite;
                        r_req.addr  <= addr & 32'hFFFF_FFFC;
                        r_req.wdata <= wdata;
                        r_req.strb  <= memwrite ? wmask : 4'b0000;
                        r_cnt       <= '0;
                    end
                end
                REQ: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (w_timeout) begin
                        r_rdata <= ERR_RDATA;
                        r_err   <= 1'b1;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (bus_rsp_valid) begin
                        r_rdata <= bus_rsp_err ? ERR_RDATA : bus_rsp_rdata;
                        if (bus_rsp_err) begin
                            r_err <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_rdata <= ERR_RDATA;
                        r_err   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Dwait         = w_dwait;
    assign bus_req_valid = (r_state == REQ);
    assign bus_req_we    = r_req.we;
    assign bus_req_addr  = r_req.addr;
    assign bus_req_wdata = r_req.wdata;
    assign bus_req_strb  = r_req.strb;
    assign rdata         = r_rdata;
    assign err           = r_err;

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: hand-written vector table, randomized accesses
// against a transaction-level model, and reset/stray-response sequences.
module tb_dmem_bridge;

    localparam int TO = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        memaccess, memwrite;
    logic [31:0] addr, wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic        Dwait;
    logic        bus_req_valid, bus_req_ready, bus_req_we;
    logic [31:0] bus_req_addr, bus_req_wdata;
    logic [3:0]  bus_req_strb;
    logic        bus_rsp_valid, bus_rsp_err;
    logic [31:0] bus_rsp_rdata;
    logic        err;

    int n_chk  = 0;
    int n_pass = 0;
    logic m_err = 1'b0;

    dmem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .memaccess(memaccess), .memwrite(memwrite),
        .addr(addr), .wdata(wdata), .wmask(wmask), .rdata(rdata), .Dwait(Dwait),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr),
        .bus_req_wdata(bus_req_wdata), .bus_req_strb(bus_req_strb),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata),
        .bus_rsp_err(bus_rsp_err), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  wm;
        int          rdly;   // valid cycles before ready is given
        int          sdly;   // WAIT cycles before the response
        logic        rerr;
        logic [31:0] rsp;
        logic        keep;   // hold memaccess high through DONE
        int          e_dw;
        int          e_vc;
        logic [31:0] e_rd;
        logic        e_err;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Drives one access through the DUT with a responsive bus model and
    // compares stall length, request count/fields and the committed result.
    task automatic do_access(input string nm, input logic we, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] wm,
                             input int rdly, input int sdly, input logic rerr,
                             input logic [31:0] rsp_d, input logic keep,
                             input int e_dw, input int e_vc,
                             input logic [31:0] e_rd, input logic e_err);
        int dw_cnt, vcnt, wcnt;
        bit hs, hs_now, done, fbad;
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        dw_cnt = 0; vcnt = 0; wcnt = 0; hs = 0; done = 0; fbad = 0;
        e_addr = a & 32'hFFFF_FFFC;
        e_strb = we ? wm : 4'h0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                memaccess = 1'b1; memwrite = we; addr = a; wdata = wd; wmask = wm;
            end
            bus_req_ready = bus_req_valid && (vcnt == rdly);
            bus_rsp_valid = hs && (wcnt == sdly);
            bus_rsp_rdata = rsp_d;
            bus_rsp_err   = rerr;
            #1;
            hs_now = 0;
            if (bus_req_valid) begin
                vcnt++;
                if (bus_req_we !== we || bus_req_addr !== e_addr ||
                    bus_req_wdata !== wd || bus_req_strb !== e_strb) fbad = 1;
                hs_now = bus_req_ready;
            end
            if (hs) wcnt++;
            if (hs_now) hs = 1;
            if (Dwait === 1'b1) begin
                dw_cnt++;
            end else begin
                done = 1;
                chk({nm, " rdata"}, rdata, e_rd);
                chk({nm, " err"}, {31'b0, err}, {31'b0, e_err});
                memaccess = keep;
                bus_req_ready = 1'b0;
                bus_rsp_valid = 1'b0;
            end
        end
        if (!done) begin
            memaccess = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        end
        chk({nm, " done_reached"}, {31'b0, done}, 32'd1);
        chk({nm, " dwait_cycles"}, dw_cnt, e_dw);
        chk({nm, " valid_cycles"}, vcnt, e_vc);
        chk({nm, " req_fields"}, {31'b0, fbad}, 32'd0);
    endtask

    // Transaction-level model: an access needs (rdly+1) REQ cycles plus
    // (sdly+1) WAIT cycles; it aborts if that exceeds TO.
    task automatic model(input int rdly, input int sdly, input logic rerr,
                         input logic [31:0] rsp, output int e_dw, output int e_vc,
                         output logic [31:0] e_rd);
        int total;
        total = rdly + sdly + 2;
        e_vc  = (rdly + 1 > TO) ? TO : rdly + 1;
        if (total > TO) begin
            e_dw = TO + 1; e_rd = ERRD; m_err = 1'b1;
        end else begin
            e_dw = total + 1;
            e_rd = rerr ? ERRD : rsp;
            if (rerr) m_err = 1'b1;
        end
    endtask

    initial begin
        int e_dw, e_vc;
        logic [31:0] e_rd, ra, rsp;
        logic rw, rerr, kp;
        int rd, sd;

        tbl[0] = '{1'b0, 32'h0000_1006, 32'h0, 4'hF, 0, 0, 1'b0, 32'h1234_5678, 1'b0, 3, 1, 32'h1234_5678, 1'b0};
        tbl[1] = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b1100, 5, 0, 1'b0, 32'h5555_0000, 1'b0, 8, 6, 32'h5555_0000, 1'b0};
        tbl[2] = '{1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 1, 1'b0, 32'h0BAD_F00D, 1'b1, 4, 1, 32'h0BAD_F00D, 1'b0};
        tbl[3] = '{1'b1, 32'h0000_0047, 32'h0102_0304, 4'b0011, 0, 0, 1'b0, 32'hCAFE_0001, 1'b0, 3, 1, 32'hCAFE_0001, 1'b0};
        tbl[4] = '{1'b0, 32'h0000_0080, 32'h0, 4'h0, 100, 0, 1'b0, 32'h0, 1'b0, 9, 8, ERRD, 1'b1};
        tbl[5] = '{1'b0, 32'h0000_0084, 32'h0, 4'h0, 0, 0, 1'b0, 32'h1111_1111, 1'b0, 3, 1, 32'h1111_1111, 1'b1};
        tbl[6] = '{1'b0, 32'h0000_0088, 32'h0, 4'h0, 0, 10, 1'b0, 32'h2222_2222, 1'b0, 9, 1, ERRD, 1'b1};
        tbl[7] = '{1'b1, 32'h0000_008C, 32'h3, 4'b0001, 1, 5, 1'b0, 32'h7777_7777, 1'b0, 9, 2, 32'h7777_7777, 1'b1};
        tbl[8] = '{1'b0, 32'h0000_0090, 32'h0, 4'h0, 7, 0, 1'b0, 32'h3333_3333, 1'b0, 9, 8, ERRD, 1'b1};
        tbl[9] = '{1'b0, 32'h0000_0094, 32'h0, 4'h0, 6, 0, 1'b0, 32'h4444_4444, 1'b0, 9, 7, 32'h4444_4444, 1'b1};

        reset = 1'b0; memaccess = 1'b0; memwrite = 1'b0; addr = '0; wdata = '0; wmask = '0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = '0; bus_rsp_err = 1'b0;
        #1;
        chk("rst dwait", {31'b0, Dwait}, 32'd0);
        chk("rst valid", {31'b0, bus_req_valid}, 32'd0);
        chk("rst rdata", rdata, 32'd0);
        chk("rst err", {31'b0, err}, 32'd0);
        chk("rst addr", bus_req_addr, 32'd0);
        memaccess = 1'b1; #1;
        chk("rst dwait_follows", {31'b0, Dwait}, 32'd1);
        memaccess = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_access($sformatf("vec%0d", i), tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].wm,
                      tbl[i].rdly, tbl[i].sdly, tbl[i].rerr, tbl[i].rsp, tbl[i].keep,
                      tbl[i].e_dw, tbl[i].e_vc, tbl[i].e_rd, tbl[i].e_err);
        end
        m_err = 1'b1;

        for (int i = 0; i < 25; i++) begin
            rw   = 1'($urandom_range(0, 1));
            ra   = $urandom;
            rsp  = $urandom;
            rd   = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 5));
            sd   = int'($urandom_range(0, 5));
            rerr = ($urandom_range(0, 7) == 0);
            kp   = 1'($urandom_range(0, 1));
            model(rd, sd, rerr, rsp, e_dw, e_vc, e_rd);
            do_access($sformatf("rnd%0d", i), rw, ra, $urandom, 4'($urandom),
                      rd, sd, rerr, rsp, kp, e_dw, e_vc, e_rd, m_err);
        end
        memaccess = 1'b0;

        // Reset while waiting for a response.
        do_access("pre_rst_to", 1'b0, 32'h200, 32'h0, 4'h0, 100, 0, 1'b0, 32'h0, 1'b0, 9, 8, ERRD, 1'b1);
        @(negedge clk);
        memaccess = 1'b1; memwrite = 1'b0; addr = 32'h100; bus_req_ready = 1'b1;
        @(negedge clk);
        chk("rstw in_req", {31'b0, bus_req_valid}, 32'd1);
        @(negedge clk);
        bus_req_ready = 1'b0;
        chk("rstw in_wait_dwait", {31'b0, Dwait}, 32'd1);
        reset = 1'b0; #1;
        chk("rstw valid", {31'b0, bus_req_valid}, 32'd0);
        chk("rstw rdata", rdata, 32'd0);
        chk("rstw err", {31'b0, err}, 32'd0);
        memaccess = 1'b0; #1;
        chk("rstw dwait", {31'b0, Dwait}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus_rsp_valid = 1'b1; bus_rsp_err = 1'b1; bus_rsp_rdata = 32'h5A5A_5A5A;
        @(negedge clk);
        bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0; #1;
        chk("late_rsp err", {31'b0, err}, 32'd0);
        chk("late_rsp rdata", rdata, 32'd0);
        chk("late_rsp valid", {31'b0, bus_req_valid}, 32'd0);
        chk("late_rsp dwait", {31'b0, Dwait}, 32'd0);

        // Reset while the request is still presented: valid must fall at once.
        @(negedge clk);
        memaccess = 1'b1; addr = 32'h300;
        @(negedge clk);
        chk("rstr in_req", {31'b0, bus_req_valid}, 32'd1);
        reset = 1'b0; #1;
        chk("rstr valid_async", {31'b0, bus_req_valid}, 32'd0);
        memaccess = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Error response, then a stray response in IDLE, then a clean load.
        do_access("rsp_err", 1'b0, 32'h400, 32'h0, 4'h0, 0, 0, 1'b1, 32'h9999_9999, 1'b0, 3, 1, ERRD, 1'b1);
        @(negedge clk);
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h0123_4567;
        @(negedge clk);
        bus_rsp_valid = 1'b0; #1;
        chk("stray rdata", rdata, ERRD);
        chk("stray err", {31'b0, err}, 32'd1);
        chk("stray valid", {31'b0, bus_req_valid}, 32'd0);
        do_access("post_stray", 1'b0, 32'h404, 32'h0, 4'h0, 0, 0, 1'b0, 32'h6666_6666, 1'b0, 3, 1, 32'h6666_6666, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
